// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Build option FIFO_ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } arbState_t;

    function automatic int idWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter.
// The master modport is the arbiter's view; slave is the producers/FIFO side.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int WORD_SIZE  = 8,
    parameter int ID_WIDTH   = idWidth(REQUESTERS)
);
    logic [REQUESTERS-1:0]           req_valid;
    logic [REQUESTERS*WORD_SIZE-1:0] req_data;
    logic [REQUESTERS-1:0]           req_ready;
    logic [WORD_SIZE-1:0]            fifo_dataIn;
    logic                            fifo_we;
    logic                            fifo_bufferFull;
    logic [ID_WIDTH-1:0]             grant_id;
    logic                            busy;

    modport master (
        input  req_valid, req_data, fifo_bufferFull,
        output req_ready, fifo_dataIn, fifo_we, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_bufferFull,
        input  req_ready, fifo_dataIn, fifo_we, grant_id, busy
    );
endinterface

// File: rtl/fifo_arb_picker.sv
// Combinational winner selection: rotate requests to start after lastGrant,
// priority-encode, un-rotate. FIFO_ARB_FIXED_PRIORITY_EN pins the start at index 0.
module fifo_arb_picker
    import fifo_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ID_WIDTH   = idWidth(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] reqValid,
    input  logic [ID_WIDTH-1:0]   lastGrant,
    output logic [ID_WIDTH-1:0]   winner,
    output logic                  anyReq
);
    logic [REQUESTERS-1:0] rotated;
    int                    startIdx;
    int                    rotIdx;

    always_comb begin
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        startIdx = 0;
`else
        startIdx = (int'(lastGrant) + 1) % REQUESTERS;
`endif
        rotated = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            rotated[i] = reqValid[(i + startIdx) % REQUESTERS];
        end
        // Descending scan so the lowest rotated position wins.
        rotIdx = 0;
        anyReq = 1'b0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rotIdx = i;
                anyReq = 1'b1;
            end
        end
        winner = ID_WIDTH'((rotIdx + startIdx) % REQUESTERS);
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between REQUESTERS producers, with a settle cycle
// after every write so bufferFull is current before the next grant.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int WORD_SIZE  = 8
) (
    input logic                  clk,
    input logic                  rst,
    fifo_write_arbiter_if.master bus
);
    localparam int ID_WIDTH = idWidth(REQUESTERS);

    arbState_t             state;
    arbState_t             stateNext;
    logic [ID_WIDTH-1:0]   lastGrant;
    logic [ID_WIDTH-1:0]   grantId;
    logic [ID_WIDTH-1:0]   winner;
    logic [WORD_SIZE-1:0]  dataReg;
    logic                  anyReq;
    logic                  grantOk;
    logic [REQUESTERS-1:0] readyVec;

    fifo_arb_picker #(
        .REQUESTERS(REQUESTERS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_picker (
        .reqValid (bus.req_valid),
        .lastGrant(lastGrant),
        .winner   (winner),
        .anyReq   (anyReq)
    );

    assign grantOk = anyReq && !bus.fifo_bufferFull;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= ID_WIDTH'(REQUESTERS - 1);
            grantId   <= '0;
            dataReg   <= '0;
        end else begin
            state <= stateNext;
            // The word is captured at the grant edge, so the producer may move on after its ready pulse.
            if (stateNext == WRITE) begin
                lastGrant <= winner;
                grantId   <= winner;
                dataReg   <= bus.req_data[int'(winner)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        stateNext = state;
        readyVec  = '0;
        case (state)
            IDLE:    if (grantOk) stateNext = WRITE;
            WRITE: begin
                stateNext         = SETTLE;
                readyVec[grantId] = 1'b1;
            end
            SETTLE:  stateNext = grantOk ? WRITE : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.fifo_we     = (state == WRITE);
    assign bus.req_ready   = readyVec;
    assign bus.busy        = (state != IDLE);
    assign bus.fifo_dataIn = dataReg;
    assign bus.grant_id    = grantId;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter with a small behavioural FIFO
// (capacity 3, posedge sample, negedge commit) for the integration sequence.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic forceFull = 1'b0;
    logic useModel = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fifo_write_arbiter_if #(.REQUESTERS(4), .WORD_SIZE(8)) bus ();

    fifo_write_arbiter #(.REQUESTERS(4), .WORD_SIZE(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: 4-entry buffer with one slot reserved, so 3 words fit.
    logic       pendWe;
    logic [7:0] pendData;
    logic [7:0] fMem [3];
    int         fCount;
    logic       dataLost;
    logic       modelFull;

    assign modelFull = (fCount == 3);
    assign bus.fifo_bufferFull = useModel ? modelFull : forceFull;

    always @(posedge clk) begin
        if (rst) begin
            pendWe <= 1'b0;
        end else begin
            pendWe   <= bus.fifo_we;
            pendData <= bus.fifo_dataIn;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            fCount   <= 0;
            dataLost <= 1'b0;
        end else if (pendWe) begin
            if (fCount == 3) dataLost <= 1'b1;
            else begin
                fMem[fCount] <= pendData;
                fCount       <= fCount + 1;
            end
        end
    end

    typedef struct {
        logic        rstIn;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        full;
        logic        we;
        logic [3:0]  ready;
        logic [7:0]  dIn;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t v(input logic r, input logic [3:0] va, input logic [31:0] d,
                               input logic f, input logic we, input logic [3:0] rdy,
                               input logic [7:0] di, input logic [1:0] g, input logic b);
        vec_t t;
        t.rstIn = r; t.valid = va; t.data = d; t.full = f;
        t.we = we; t.ready = rdy; t.dIn = di; t.gid = g; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutputs(input string tag, input logic we, input logic [3:0] rdy,
                                input logic [7:0] di, input logic [1:0] g, input logic b);
        check({tag, ".we"},    32'(bus.fifo_we),     32'(we));
        check({tag, ".ready"}, 32'(bus.req_ready),   32'(rdy));
        check({tag, ".dataIn"},32'(bus.fifo_dataIn), 32'(di));
        check({tag, ".grant"}, 32'(bus.grant_id),    32'(g));
        check({tag, ".busy"},  32'(bus.busy),        32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] order [5];
    int         readyCount;
    int         word;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;

        //             rst valid data          full  we rdy    dIn    g  busy
        vecs[0]  = v(1, 4'hF, 32'h44332211, 0,   0, 4'h0, 8'h00, 0, 0);
        vecs[1]  = v(1, 4'hF, 32'h44332211, 0,   0, 4'h0, 8'h00, 0, 0);
        vecs[2]  = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h00, 0, 0);
        vecs[3]  = v(0, 4'h2, 32'h0000A500, 0,   1, 4'h2, 8'hA5, 1, 1);
        vecs[4]  = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'hA5, 1, 1);
        vecs[5]  = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'hA5, 1, 0);
        for (int i = 6; i <= 10; i++)
            vecs[i] = v(0, 4'h4, 32'h005C0000, 1, 0, 4'h0, 8'hA5, 1, 0);
        vecs[11] = v(0, 4'h4, 32'h005C0000, 0,   1, 4'h4, 8'h5C, 2, 1);
        vecs[12] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h5C, 2, 1);
        vecs[13] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h5C, 2, 0);
        vecs[14] = v(0, 4'h8, 32'h77000000, 0,   1, 4'h8, 8'h77, 3, 1);
        vecs[15] = v(0, 4'h8, 32'h78000000, 1,   0, 4'h0, 8'h77, 3, 1);
        vecs[16] = v(0, 4'h8, 32'h78000000, 1,   0, 4'h0, 8'h77, 3, 0);
        vecs[17] = v(0, 4'h8, 32'h78000000, 0,   1, 4'h8, 8'h78, 3, 1);
        vecs[18] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h78, 3, 1);
        vecs[19] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h78, 3, 0);
        vecs[20] = v(0, 4'h3, 32'h00001110, 0,   1, 4'h1, 8'h10, 0, 1);
        vecs[21] = v(0, 4'h3, 32'h00001120, 0,   0, 4'h0, 8'h10, 0, 1);
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        vecs[22] = v(0, 4'h3, 32'h00001120, 0,   1, 4'h1, 8'h20, 0, 1);
        vecs[23] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h20, 0, 1);
        vecs[24] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h20, 0, 0);
        order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        vecs[22] = v(0, 4'h3, 32'h00001120, 0,   1, 4'h2, 8'h11, 1, 1);
        vecs[23] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h11, 1, 1);
        vecs[24] = v(0, 4'h0, 32'h00000000, 0,   0, 4'h0, 8'h11, 1, 0);
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

        for (int i = 0; i < 25; i++) begin
            rst           = vecs[i].rstIn;
            bus.req_valid = vecs[i].valid;
            bus.req_data  = vecs[i].data;
            forceFull     = vecs[i].full;
            tick();
            checkOutputs($sformatf("vec%0d", i), vecs[i].we, vecs[i].ready,
                         vecs[i].dIn, vecs[i].gid, vecs[i].busy);
        end

        // Fairness: all four requesters held valid from reset.
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = 32'hC3C2C1C0;
        forceFull = 1'b0;
        tick();
        checkOutputs("fair.rst", 0, 4'h0, 8'h00, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("fair%0d.we", k), 32'(bus.fifo_we), 32'(k % 2));
            if (k % 2 == 1) begin
                check($sformatf("fair%0d.grant", k), 32'(bus.grant_id), 32'(order[(k-1)/2]));
                check($sformatf("fair%0d.ready", k), 32'(bus.req_ready), 32'(4'h1 << order[(k-1)/2]));
                check($sformatf("fair%0d.dataIn", k), 32'(bus.fifo_dataIn), 32'(8'hC0 + order[(k-1)/2]));
            end else begin
                check($sformatf("fair%0d.ready", k), 32'(bus.req_ready), 32'h0);
            end
        end

        // Reset asserted while in WRITE, then requester 0 must win first.
        tick();
`ifdef FIFO_ARB_FIXED_PRIORITY_EN
        checkOutputs("midrst.pre", 1, 4'h1, 8'hC0, 0, 1);
`else
        checkOutputs("midrst.pre", 1, 4'h2, 8'hC1, 1, 1);
`endif
        rst = 1'b1;
        tick();
        checkOutputs("midrst.rst", 0, 4'h0, 8'h00, 0, 0);
        rst = 1'b0;
        tick();
        checkOutputs("midrst.post", 1, 4'h1, 8'hC0, 0, 1);

        // Integration with the behavioural FIFO, no reader.
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        useModel = 1'b1;
        rst = 1'b0;
        word = 1;
        readyCount = 0;
        bus.req_data  = 32'h00000001;
        bus.req_valid = 4'h1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.req_ready != 4'h0) begin
                if (bus.req_ready != 4'h1)
                    check("int.readyLane", 32'(bus.req_ready), 32'h1);
                readyCount++;
                word++;
                if (word > 5) bus.req_valid = 4'h0;
                else bus.req_data = 32'(word);
            end
        end
        check("int.readyCount", 32'(readyCount), 32'd3);
        check("int.fifoCount",  32'(fCount), 32'd3);
        check("int.mem0", 32'(fMem[0]), 32'h01);
        check("int.mem1", 32'(fMem[1]), 32'h02);
        check("int.mem2", 32'(fMem[2]), 32'h03);
        check("int.dataLost", 32'(dataLost), 32'h0);
        check("int.idleWhenFull", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
